// File: rtl/seg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_reader
// Function : Decodes a multiplexed seven-segment bus back to BCD and
//            publishes a word once identical frames repeat.
// Revision : 1.0
// ============================================================================
module seg_scan_reader #(
    parameter int DIGITS       = 4,
    parameter int STABLE_SCANS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    input  logic [DIGITS-1:0]   dig_en,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                valid,
    output logic                err,
    output logic                locked
);
    localparam int         c_IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [0:0] c_SYNC    = 1'b0;
    localparam logic [0:0] c_COLLECT = 1'b1;
    localparam logic [3:0] c_STABLE  = 4'(STABLE_SCANS);

    // Bit 4 flags an undecodable pattern; its value field reads as blank.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1111110: seg_decode = 5'h00;
            7'b0110000: seg_decode = 5'h01;
            7'b1101101: seg_decode = 5'h02;
            7'b1111001: seg_decode = 5'h03;
            7'b0110011: seg_decode = 5'h04;
            7'b1011011: seg_decode = 5'h05;
            7'b1011111: seg_decode = 5'h06;
            7'b1110000: seg_decode = 5'h07;
            7'b1111111: seg_decode = 5'h08;
            7'b1110011: seg_decode = 5'h09;
            7'b0000000: seg_decode = 5'h0F;
            default:    seg_decode = 5'h1F;
        endcase
    endfunction

    logic [0:0]          r_state, w_state_next;
    logic [DIGITS-1:0]   r_seen;
    logic                r_bad;
    logic [4*DIGITS-1:0] r_buf, r_cand, r_prev, r_tgt;
    logic                r_cand_bad, r_cand_vld, r_tgt_lock, r_pub, r_err_d;
    logic [3:0]          r_cnt, w_cnt_inc, w_cnt_next;
    logic [4:0]          w_dec;
    logic [3:0]          w_val;
    logic [c_IW-1:0]     w_idx;
    logic                w_pat_bad, w_idle, w_single, w_multi, w_d0, w_all_seen;
    logic                w_start, w_store, w_close, w_short, w_err_now, w_clr_cnt, w_pub;

    always_comb begin
        w_dec      = seg_decode(seg_in);
        w_pat_bad  = w_dec[4];
        w_val      = w_dec[3:0];
        w_idle     = (dig_en == '0);
        w_single   = $onehot(dig_en);
        w_multi    = !w_idle && !w_single;
        w_d0       = w_single && dig_en[0];
        w_all_seen = &r_seen;
        w_idx      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_en[k]) w_idx = c_IW'(k);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_SYNC;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_SYNC:    if (w_d0) w_state_next = c_COLLECT;
            c_COLLECT: if (w_multi) w_state_next = c_SYNC;
            default:   w_state_next = c_SYNC;
        endcase
    end

    // Digit 0 always opens a new frame, whether it closes one or restarts.
    always_comb begin
        w_start   = w_d0;
        w_store   = (r_state == c_COLLECT) && w_single && !dig_en[0];
        w_close   = (r_state == c_COLLECT) && w_d0 && w_all_seen;
        w_short   = (r_state == c_COLLECT) && w_d0 && !w_all_seen;
        w_err_now = w_multi || ((w_start || w_store) && w_pat_bad) || w_short;
        w_clr_cnt = w_multi || w_short;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf      <= '1;
            r_seen     <= '0;
            r_bad      <= 1'b0;
            r_cand     <= '1;
            r_cand_bad <= 1'b0;
            r_cand_vld <= 1'b0;
        end else begin
            r_cand_vld <= w_close;
            if (w_close) begin
                r_cand     <= r_buf;
                r_cand_bad <= r_bad;
            end
            if (w_start) begin
                r_seen     <= DIGITS'(1);
                r_bad      <= w_pat_bad;
                r_buf[3:0] <= w_val;
            end else if (w_store) begin
                r_seen[w_idx]        <= 1'b1;
                r_buf[4*w_idx +: 4] <= w_val;
                if (w_pat_bad) r_bad <= 1'b1;
            end
        end
    end

    // r_tgt shadows the word about to land in bcd_out, so back-to-back
    // closes compare against the pending publish rather than a stale output.
    always_comb begin
        w_cnt_inc  = (r_cnt >= c_STABLE) ? c_STABLE : r_cnt + 4'd1;
        w_cnt_next = (r_cand == r_prev) ? w_cnt_inc : 4'd1;
        w_pub      = r_cand_vld && !r_cand_bad && (w_cnt_next == c_STABLE) &&
                     ((r_cand != r_tgt) || !r_tgt_lock);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_prev     <= '1;
            r_tgt      <= '1;
            r_tgt_lock <= 1'b0;
            r_pub      <= 1'b0;
            r_err_d    <= 1'b0;
            err        <= 1'b0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            bcd_out    <= '1;
        end else begin
            if (r_cand_vld) begin
                if (r_cand_bad) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt  <= w_cnt_next;
                    r_prev <= r_cand;
                end
            end
            if (w_clr_cnt) r_cnt <= '0;
            r_pub <= w_pub;
            if (w_pub) begin
                r_tgt      <= r_cand;
                r_tgt_lock <= 1'b1;
            end
            r_err_d <= w_err_now;
            err     <= r_err_d;
            valid   <= r_pub;
            if (r_pub) begin
                bcd_out <= r_tgt;
                locked  <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_seg_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_reader
// Function : Frame-level self-checking bench for seg_scan_reader.
// Revision : 1.0
// ============================================================================
module tb_seg_scan_reader;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_en = '0;
    logic [15:0] bcd_out;
    logic        valid, err, locked;

    int checks = 0, failures = 0;
    int n_valid = 0, n_err = 0;

    // Reference model: outcome of each closed frame, tracked per frame.
    logic [15:0] m_bcd = 16'hFFFF;
    bit          m_locked = 1'b0;
    int          m_valid = 0, m_err = 0;
    logic [15:0] run[$];
    bit          p_vld = 1'b0, p_bad = 1'b0, p_complete = 1'b0;
    logic [15:0] p_word = '0;

    seg_scan_reader #(.DIGITS(4), .STABLE_SCANS(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en),
        .bcd_out(bcd_out), .valid(valid), .err(err), .locked(locked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (err)   n_err++;
    end

    function automatic logic [6:0] enc(input logic [3:0] v);
        case (v)
            4'd0: enc = 7'b1111110;  4'd1: enc = 7'b0110000;
            4'd2: enc = 7'b1101101;  4'd3: enc = 7'b1111001;
            4'd4: enc = 7'b0110011;  4'd5: enc = 7'b1011011;
            4'd6: enc = 7'b1011111;  4'd7: enc = 7'b1110000;
            4'd8: enc = 7'b1111111;  4'd9: enc = 7'b1110011;
            default: enc = 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic [6:0] s);
        @(negedge clk);
        dig_en = d;
        seg_in = s;
    endtask

    task automatic m_close(output bit pub);
        pub = 1'b0;
        if (!p_vld) return;
        if (!p_complete) begin
            m_err++;
            run.delete();
        end else if (p_bad) begin
            run.delete();
        end else begin
            bit same = 1'b1;
            run.push_back(p_word);
            if (run.size() < S) same = 1'b0;
            else for (int i = 1; i < S; i++)
                if (run[run.size()-1-i] != p_word) same = 1'b0;
            if (same && (p_word != m_bcd || !m_locked)) begin
                pub = 1'b1; m_bcd = p_word; m_locked = 1'b1; m_valid++;
            end
        end
    endtask

    task automatic frame(input logic [15:0] w, input int bad_dig, input int miss_dig, input bit slow0);
        int ord[3];
        int j, t;
        bit pub;
        m_close(pub);
        drive(4'b0001, enc(w[3:0]));
        if (slow0) begin
            @(negedge clk); chk("valid_lat_t1", valid, 0); dig_en = '0;
            @(negedge clk); chk("valid_lat_t2", valid, 0);
            @(negedge clk); chk("valid_lat_t3", valid, 32'(pub));
        end
        ord = '{1, 2, 3};
        for (int i = 2; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        foreach (ord[i]) begin
            int d;
            d = ord[i];
            if (d == miss_dig) continue;
            if ($urandom_range(0, 1) == 1) drive(4'b0000, 7'($urandom));
            if (d == bad_dig) begin
                drive(4'(1 << d), 7'b0000001);
                m_err++;
                @(negedge clk); chk("err_lat_early", err, 0); dig_en = '0;
                @(negedge clk); chk("err_lat_pulse", err, 1);
            end else begin
                if ($urandom_range(0, 1) == 1)
                    drive(4'(1 << d), enc(4'($urandom_range(0, 9))));
                drive(4'(1 << d), enc(w[4*d +: 4]));
            end
        end
        p_vld = 1'b1; p_word = w; p_bad = (bad_dig >= 0); p_complete = (miss_dig < 0);
    endtask

    task automatic settle(input string tag);
        repeat (4) drive(4'b0000, 7'($urandom));
        #1;
        chk({tag, "_valid_cnt"}, n_valid, m_valid);
        chk({tag, "_err_cnt"}, n_err, m_err);
        chk({tag, "_bcd"}, bcd_out, m_bcd);
        chk({tag, "_locked"}, locked, 32'(m_locked));
    endtask

    initial begin
        logic [15:0] w;
        int reps, bad;
        bit pub;
        repeat (3) @(negedge clk);
        chk("rst_bcd", bcd_out, 16'hFFFF);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_locked", locked, 0);
        rst_n = 1'b1;

        repeat (3) frame(16'h1234, -1, -1, 1'b0);
        frame(16'h1235, -1, -1, 1'b0);
        settle("scan1234");
        chk("scan1234_one_valid", n_valid, 1);
        frame(16'h1235, -1, -1, 1'b0);
        frame(16'h1235, -1, -1, 1'b1);
        frame(16'h1235, -1, -1, 1'b0);
        settle("scan1235");
        chk("scan1235_word", bcd_out, 16'h1235);

        frame(16'h1234, 2, -1, 1'b0);
        frame(16'h1234, -1, -1, 1'b0);
        frame(16'h1234, -1, -1, 1'b0);
        settle("badpat_first_good");
        chk("badpat_unchanged", bcd_out, 16'h1235);
        frame(16'h1234, -1, -1, 1'b0);
        settle("badpat_second_good");

        m_close(pub);
        drive(4'b0001, enc(4'd4));
        drive(4'b0010, enc(4'd3));
        drive(4'b0011, enc(4'd8));
        m_err++; run.delete(); p_vld = 1'b0;
        repeat (3) frame(16'h5678, -1, -1, 1'b0);
        settle("multi");

        frame(16'h5678, -1, 3, 1'b0);
        frame(16'hF123, -1, -1, 1'b0);
        settle("missing_digit");
        frame(16'hF123, -1, -1, 1'b0);
        frame(16'hF123, -1, -1, 1'b0);
        settle("blank_digit");
        chk("blank_word", bcd_out, 16'hF123);

        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 4; k++) w[4*k +: 4] = 4'($urandom_range(0, 9));
            reps = $urandom_range(1, 3);
            for (int r = 0; r < reps; r++) begin
                bad = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : -1;
                frame(w, bad, -1, 1'b0);
            end
        end
        settle("random");

        drive(4'b0010, enc(4'd1));
        drive(4'b0100, enc(4'd2));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_bcd", bcd_out, 16'hFFFF);
        chk("midrst_locked", locked, 0);
        chk("midrst_valid", valid, 0);
        m_bcd = 16'hFFFF; m_locked = 1'b0; run.delete(); p_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) frame(16'h0042, -1, -1, 1'b0);
        settle("after_rst");
        chk("after_rst_word", bcd_out, 16'h0042);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
